// File: rtl/wb_mic_pkg.sv
// Shared register map, control bit positions and sequencer state encoding for wb_mic_ctrl.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wb_mic_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DIV    = 8'h04;
  localparam logic [7:0] ADDR_WINDOW = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_DATA   = 8'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/wb_mic_fifo.sv
// Synchronous FIFO holding per-window ones-counts until the CPU drains them.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: push while full is dropped unless a pop frees a slot in the same cycle; flush beats both.
module wb_mic_fifo #(
  parameter int CNT_W   = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic [CNT_W-1:0]   i_push_dat,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_head_dat,
  output logic               o_empty,
  output logic               o_full,
  output logic [FIFO_AW:0]   o_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [CNT_W-1:0]   r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               w_do_pop;
  logic               w_do_push;

  assign o_empty    = (r_level == '0);
  assign o_full     = (r_level == (FIFO_AW+1)'(DEPTH));
  assign o_level    = r_level;
  assign o_head_dat = r_mem[r_rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointer and occupancy tracking; flush returns to empty.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/wb_mic_ctrl.sv
// Wishbone slave that samples the PDM mic bit on divided ticks and queues a ones-count per window.
// Latency: mic is 2-flop synchronized; a window commits one cycle after its last tick; bus ack one cycle after strobe.
// Backpressure: counts arriving at a full FIFO are dropped and flagged in sticky OVF; bus never stalls.
module wb_mic_ctrl
  import wb_mic_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        mic,
  output logic        irq
);

  logic             r_mic_s1, r_mic_s2;
  logic             r_en, r_irq_en, r_flush, r_ovf;
  logic [DIV_W-1:0] r_div, r_div_cnt;
  logic [CNT_W-1:0] r_window, r_win_cnt, r_acc;
  logic             r_ack, r_irq;
  logic [31:0]      r_dat;
  state_t           r_state, w_state_nxt;

  logic             w_rd, w_wr, w_pop, w_tick, w_push, w_win_last, w_ovf_set;
  logic [7:0]       w_adr;
  logic [31:0]      w_rd_dat;
  logic [CNT_W-1:0] w_acc_inc, w_fifo_head;
  logic             w_fifo_empty, w_fifo_full;
  logic [FIFO_AW:0] w_fifo_level;
  logic             w_unused;

  assign w_adr    = wb_adr_i[7:0];
  assign w_rd     = wb_stb_i & wb_cyc_i & ~wb_we_i & ~r_ack;
  assign w_wr     = wb_stb_i & wb_cyc_i &  wb_we_i & ~r_ack;
  assign w_pop    = w_rd & (w_adr == ADDR_DATA);
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i};

  // A zero window behaves as a one-tick window.
  assign w_win_last = (r_window == '0) ? 1'b1 : (r_win_cnt >= r_window - CNT_W'(1));
  assign w_acc_inc  = (r_acc == '1) ? r_acc : r_acc + CNT_W'(r_mic_s2);
  // Flush wins over a coincident push, and a coincident pop frees room, so neither counts as overflow.
  assign w_ovf_set  = w_push & w_fifo_full & ~w_pop & ~r_flush;

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq      = r_irq;

  // Two-flop synchronizer for the asynchronous mic bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mic_s1 <= 1'b0;
      r_mic_s2 <= 1'b0;
    end else begin
      r_mic_s1 <= mic;
      r_mic_s2 <= r_mic_s1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sequencer next state, tick and push strobes; clearing EN overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:   if (r_en) w_state_nxt = S_RUN;
      S_RUN: begin
        w_tick = (r_div_cnt >= r_div);
        if (w_tick && w_win_last) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_push      = 1'b1;
        w_state_nxt = S_RUN;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (!r_en) begin
      w_state_nxt = S_IDLE;
      w_push      = 1'b0;
    end
  end

  // Divider, window counter and accumulator; divider pauses during COMMIT.
  always_ff @(posedge clk) begin
    if (reset || !r_en) begin
      r_div_cnt <= '0;
      r_win_cnt <= '0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_tick) begin
            r_div_cnt <= '0;
            r_win_cnt <= r_win_cnt + CNT_W'(1);
            r_acc     <= w_acc_inc;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_COMMIT: begin
          r_win_cnt <= '0;
          r_acc     <= '0;
        end
        default: begin
          r_div_cnt <= '0;
          r_win_cnt <= '0;
          r_acc     <= '0;
        end
      endcase
    end
  end

  // Read data mux for the addressed register.
  always_comb begin
    w_rd_dat = '0;
    case (w_adr)
      ADDR_CTRL: begin
        w_rd_dat[CTRL_EN]     = r_en;
        w_rd_dat[CTRL_IRQ_EN] = r_irq_en;
      end
      ADDR_DIV:    w_rd_dat[DIV_W-1:0] = r_div;
      ADDR_WINDOW: w_rd_dat[CNT_W-1:0] = r_window;
      ADDR_STATUS: begin
        w_rd_dat[STAT_EMPTY] = w_fifo_empty;
        w_rd_dat[STAT_FULL]  = w_fifo_full;
        w_rd_dat[STAT_OVF]   = r_ovf;
        w_rd_dat[STAT_LEVEL_LSB+FIFO_AW:STAT_LEVEL_LSB] = w_fifo_level;
      end
      ADDR_DATA:   if (!w_fifo_empty) w_rd_dat[CNT_W-1:0] = w_fifo_head;
      default:     w_rd_dat = '0;
    endcase
  end

  // Bus handshake, register writes, sticky overflow and registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_flush  <= 1'b0;
      r_div    <= '0;
      r_window <= '0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_ack   <= w_rd | w_wr;
      r_flush <= 1'b0;
      r_irq   <= r_irq_en & ~w_fifo_empty;
      if (w_wr) begin
        case (w_adr)
          ADDR_CTRL: begin
            r_en     <= wb_dat_i[CTRL_EN];
            r_irq_en <= wb_dat_i[CTRL_IRQ_EN];
            r_flush  <= wb_dat_i[CTRL_FLUSH];
          end
          ADDR_DIV:    r_div    <= wb_dat_i[DIV_W-1:0];
          ADDR_WINDOW: r_window <= wb_dat_i[CNT_W-1:0];
          ADDR_STATUS: if (wb_dat_i[STAT_OVF]) r_ovf <= 1'b0;
          default: ;
        endcase
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_rd)      r_dat <= w_rd_dat;
      else if (w_wr) r_dat <= '0;
    end
  end

  wb_mic_fifo #(
    .CNT_W   (CNT_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (r_acc),
    .i_pop      (w_pop),
    .i_flush    (r_flush),
    .o_head_dat (w_fifo_head),
    .o_empty    (w_fifo_empty),
    .o_full     (w_fifo_full),
    .o_level    (w_fifo_level)
  );

endmodule

// File: tb/tb_wb_mic_ctrl.sv
// Directed bench for wb_mic_ctrl: bus tasks queue expected read data, a monitor checks each ack.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_mic_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        irq;
  logic        mic_lvl, mic_tog, tog_en;
  logic        mic;

  assign mic = tog_en ? mic_tog : mic_lvl;

  wb_mic_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .mic      (mic),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  bit          chk_q [$];
  string       name_q [$];
  logic        prev_ack = 1'b0;
  logic [31:0] m_exp;
  bit          m_chk;
  string       m_name;

  // Square wave with an 8-clock period for the density test.
  initial begin
    mic_tog = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      mic_tog = ~mic_tog;
    end
  end

  // Monitor: every ack pops one scoreboard entry and compares read data.
  always @(negedge clk) begin
    if (wb_ack_o) begin
      checks++;
      if (prev_ack) begin
        errors++;
        $display("FAIL ack_pulse: ack high on two consecutive cycles");
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack with nothing outstanding, dat=%h", wb_dat_o);
      end else begin
        m_exp  = exp_q.pop_front();
        m_chk  = chk_q.pop_front();
        m_name = name_q.pop_front();
        if (m_chk) begin
          checks++;
          if (wb_dat_o !== m_exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", m_name, wb_dat_o, m_exp);
          end
        end
      end
    end
    prev_ack = wb_ack_o;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, e);
    end
  endtask

  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d,
                     input bit c, input logic [31:0] e, input string n);
    int k;
    exp_q.push_back(e);
    chk_q.push_back(c);
    name_q.push_back(n);
    @(negedge clk);
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_we_i  = w;
    wb_adr_i = 32'h8000_0000 | {24'h0, a};
    wb_dat_i = d;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!wb_ack_o && k < 16);
    if (!wb_ack_o) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within 16 cycles", n);
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
      void'(name_q.pop_back());
    end
    @(negedge clk);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string n);
    bus(1'b0, a, 32'h0, 1'b1, e, n);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 32'h0, "write");
  endtask

  task automatic read_reset_values(input string tag);
    rd(8'h00, 32'h0, {tag, "_ctrl"});
    rd(8'h04, 32'h0, {tag, "_div"});
    rd(8'h08, 32'h0, {tag, "_window"});
    rd(8'h0C, 32'h1, {tag, "_status"});
    rd(8'h10, 32'h0, {tag, "_data"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = 4'hF;
    mic_lvl  = 1'b1;
    tog_en   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    read_reset_values("rst");
    rd(8'h14, 32'h0, "unmapped_rd");

    // Constant 1 input: one window of 8 ticks gives 8.
    wr(8'h04, 32'd3);
    wr(8'h08, 32'd8);
    wr(8'h14, 32'hFFFF_FFFF);
    rd(8'h04, 32'd3, "div_rb");
    rd(8'h08, 32'd8, "window_rb");
    wr(8'h00, 32'h1);
    repeat (50) @(negedge clk);
    wr(8'h00, 32'h0);
    rd(8'h0C, 32'h0000_0100, "one_window_status");
    chk("irq_disabled", {31'h0, irq}, 32'h0);
    rd(8'h10, 32'd8, "ones_window");
    rd(8'h0C, 32'h1, "drained_status");

    // 50% density: each window counts 4; irq gated by IRQ_EN.
    tog_en = 1'b1;
    wr(8'h00, 32'h1);
    repeat (80) @(negedge clk);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(8'h00, 32'h2);
    repeat (2) @(negedge clk);
    chk("irq_pending", {31'h0, irq}, 32'h1);
    rd(8'h0C, 32'h0000_0200, "toggle_status");
    rd(8'h10, 32'd4, "toggle_data0");
    rd(8'h10, 32'd4, "toggle_data1");
    rd(8'h0C, 32'h1, "toggle_drained");
    repeat (2) @(negedge clk);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    tog_en = 1'b0;
    wr(8'h00, 32'h0);
    repeat (4) @(negedge clk);

    // Overrun: 18 windows into a 16-deep FIFO.
    wr(8'h00, 32'h1);
    repeat (620) @(negedge clk);
    wr(8'h00, 32'h0);
    rd(8'h0C, 32'h0000_1006, "full_ovf_status");
    wr(8'h0C, 32'h4);
    rd(8'h0C, 32'h0000_1002, "ovf_cleared");

    // Short windows (4 ticks, 1 clk each): the commit lands 6 clocks after EN.
    wr(8'h04, 32'd0);
    wr(8'h08, 32'd4);
    wr(8'h00, 32'h1);
    repeat (4) @(negedge clk);
    rd(8'h10, 32'd8, "pop_with_commit");
    wr(8'h00, 32'h0);
    rd(8'h0C, 32'h0000_1002, "full_pop_push_no_ovf");

    for (int i = 0; i < 15; i++) rd(8'h10, 32'd8, "drain");
    rd(8'h10, 32'd4, "drain_tail");
    rd(8'h10, 32'd0, "read_empty");
    rd(8'h0C, 32'h1, "after_drain");

    // Flush aligned with the second commit.
    wr(8'h00, 32'h1);
    repeat (8) @(negedge clk);
    wr(8'h00, 32'h5);
    rd(8'h00, 32'h1, "flush_reads_zero");
    wr(8'h00, 32'h0);
    rd(8'h0C, 32'h1, "flush_beats_commit");

    // WINDOW=0 acts as a single-tick window.
    wr(8'h04, 32'd3);
    wr(8'h08, 32'd0);
    wr(8'h00, 32'h1);
    repeat (7) @(negedge clk);
    wr(8'h00, 32'h0);
    rd(8'h10, 32'd1, "window_zero");
    rd(8'h0C, 32'h1, "window_zero_status");

    // Disable mid-window discards the partial count.
    wr(8'h08, 32'd8);
    wr(8'h00, 32'h1);
    repeat (20) @(negedge clk);
    wr(8'h00, 32'h0);
    repeat (5) @(negedge clk);
    wr(8'h00, 32'h1);
    repeat (50) @(negedge clk);
    wr(8'h00, 32'h0);
    rd(8'h10, 32'd8, "restart_count");
    rd(8'h0C, 32'h1, "restart_status");

    // Reset mid-window with data pending.
    wr(8'h00, 32'h3);
    repeat (50) @(negedge clk);
    chk("irq_before_reset", {31'h0, irq}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst2_ack", {31'h0, wb_ack_o}, 32'h0);
    chk("rst2_irq", {31'h0, irq}, 32'h0);
    read_reset_values("rst2");

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_mic_ctrl.md
Name: wb_mic_ctrl

Overview:
- Wishbone slave controller that sequences sampling of the 1-bit microphone input on the LM32 SoC bus.
- A programmable divider generates sample ticks. The synchronized mic bit is accumulated over a programmable window, giving a ones-count per window (PDM density).
- Each count is pushed into a small FIFO that the CPU drains over Wishbone.
- Raises a level interrupt while data is pending.

Parameters:
- DIV_W, 16, width of clock-divider register/counter.
- CNT_W, 16, width of window length, accumulator and FIFO data.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- wb_stb_i  in  1  Wishbone strobe.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_ack_o  out  1  Wishbone acknowledge.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  address; only [7:0] decoded.
- wb_sel_i  in  4  byte selects; ignored, full-word access only.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- mic  in  1  asynchronous microphone bit.
- irq  out  1  level interrupt.

Behaviour:
- Reset:
  - wb_ack_o=0, wb_dat_o=0, irq=0.
  - CTRL=0, DIV=0, WINDOW=0.
  - FIFO empty, overflow=0, FSM=IDLE, accumulator=0, tick and window counters=0.
  - Reset asserted mid-window discards the partial accumulation.
- Bus access:
  - rd = stb&cyc&~we; wr = stb&cyc&we.
  - If (rd|wr) & ~ack, set ack=1 for exactly one cycle; otherwise ack=0. Back-to-back accesses therefore see ack on alternate cycles.
  - wb_dat_o is registered in the same cycle ack is set.
  - Unmapped addresses: reads return 0, writes are ignored.
- Register map (wb_adr_i[7:0]):
  - 0x00 CTRL (R/W): bit0 EN, bit1 IRQ_EN, bit2 FLUSH. FLUSH is write-only, self-clearing, and reads as 0.
  - 0x04 DIV (R/W) [DIV_W-1:0]: one tick every DIV+1 clocks.
  - 0x08 WINDOW (R/W) [CNT_W-1:0]: ticks per window. Value 0 is treated as 1.
  - 0x0C STATUS: bit0 EMPTY, bit1 FULL, bit2 OVF, [8+FIFO_AW:8] LEVEL (0..depth). Writing 1 to bit2 clears OVF.
  - 0x10 DATA (R): returns the FIFO head (zero-extended) and pops it in the ack cycle. Read on empty returns 0 with no state change.
- Input sync: mic passes through 2 flip-flops before use (2-cycle latency).
- FSM states:
  - IDLE: counters held at 0. EN=1 goes to RUN on the next cycle.
  - RUN:
    - Divider counts 0..DIV. At DIV it wraps to 0 and generates a tick.
    - On each tick: acc += mic_sync and the window counter increments.
    - On the tick where window count = WINDOW-1 (or the first tick when WINDOW=0), go to COMMIT.
  - COMMIT (1 cycle):
    - Push acc+last sample to the FIFO, then clear acc and the window counter, and return to RUN.
    - If the FIFO is full: drop the value and set OVF (sticky).
- EN=0 in any state: next state is IDLE and the partial window is discarded.
- Writing DIV or WINDOW while running: takes effect from the next compare; no window restart.
- FLUSH: empties the FIFO in the following cycle and does not touch OVF or the window in progress.
  - FLUSH coincident with COMMIT: flush wins and the push is dropped without setting OVF.
- Push and pop in the same cycle: both occur and LEVEL is unchanged. If the FIFO was empty, the pop returns 0 and the push succeeds. If it was full, the pop frees a slot and the push succeeds without OVF.
- Accumulator saturates at 2**CNT_W-1; it cannot exceed WINDOW anyway.
- irq = IRQ_EN & ~EMPTY, registered (1-cycle delay after the FIFO state change).

Decomposition:
- Package wb_mic_pkg holds:
  - register offsets ADDR_CTRL, ADDR_DIV, ADDR_WINDOW, ADDR_STATUS, ADDR_DATA;
  - CTRL bit indices;
  - the FSM state encoding S_IDLE/S_RUN/S_COMMIT.
- One sub-module, wb_mic_fifo: synchronous FIFO with push, pop, flush, head data, empty, full and level, parameterized by CNT_W and FIFO_AW. The FSM, divider, synchronizer and bus decode stay in wb_mic_ctrl.

Test Plan:
- Reset then reads of 0x00..0x10 -> all return 0 except STATUS=0x1 (EMPTY); ack high exactly 1 cycle per access.
- DIV=3, WINDOW=8, EN=1, mic held 1 -> first value pushed ≈ 32+sync clocks later; DATA read returns 8; STATUS returns to EMPTY.
- mic toggling every 4 clocks, DIV=3, WINDOW=8 -> DATA sequence all 4; irq asserts only when IRQ_EN=1 and FIFO non-empty.
- Run 17 windows without reading -> LEVEL=16, FULL=1, OVF=1; write STATUS 0x4 -> OVF=0; 16 DATA reads drain in order; 17th read returns 0.
- Pop aligned with COMMIT while FIFO full -> LEVEL stays 16, no OVF; FLUSH during COMMIT -> LEVEL=0, OVF unchanged.
- EN cleared mid-window, then set again -> the next pushed value counts only post-restart ticks (WINDOW=8, mic=1 -> 8); reset asserted mid-window -> all registers and the FIFO return to reset values.
